// File: rtl/paxi2axi.sv
// Unified AXI address channel splitter: 2-deep in-order request FIFO
// feeding registered AW/AR channels with per-direction outstanding credit.
module paxi2axi #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic [ADDR_WIDTH-1:0] paxi_aaddr,
    input  logic [7:0]            paxi_alen,
    input  logic [2:0]            paxi_asize,
    input  logic [1:0]            paxi_aburst,
    input  logic                  paxi_atype,
    input  logic                  paxi_avalid,
    output logic                  paxi_aready,

    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [7:0]            axi_awlen,
    output logic [2:0]            axi_awsize,
    output logic [1:0]            axi_awburst,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,

    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,

    input  logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic                  axi_rvalid,
    input  logic                  axi_rready,
    input  logic                  axi_rlast,

    output logic [CW-1:0]         wr_outstanding,
    output logic [CW-1:0]         rd_outstanding
);

    typedef struct packed {
        logic                  typ;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } req_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    req_t       fifo_q [2];
    req_t       head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       ready_q;

    logic push;
    logic pop;
    logic head_valid;
    logic aw_free;
    logic ar_free;
    logic wr_dec;
    logic rd_dec;
    logic wr_credit;
    logic rd_credit;
    logic wr_disp;
    logic rd_disp;

    // ready_q keeps aready low until the first edge after reset release
    assign paxi_aready = ready_q & (count != 2'd2);
    assign push        = paxi_avalid & paxi_aready;
    assign head        = fifo_q[rd_ptr];
    assign head_valid  = (count != 2'd0);

    assign aw_free = ~axi_awvalid | axi_awready;
    assign ar_free = ~axi_arvalid | axi_arready;

    assign wr_dec = axi_bvalid & axi_bready & (wr_outstanding != '0);
    assign rd_dec = axi_rvalid & axi_rready & axi_rlast
                  & (rd_outstanding != '0);

    // a completion in the same cycle frees the credit for this dispatch
    assign wr_credit = (wr_outstanding < MAX_CNT) | wr_dec;
    assign rd_credit = (rd_outstanding < MAX_CNT) | rd_dec;

    assign wr_disp = head_valid & head.typ & aw_free & wr_credit;
    assign rd_disp = head_valid & ~head.typ & ar_free & rd_credit;
    assign pop     = wr_disp | rd_disp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{
                typ:   paxi_atype,
                addr:  paxi_aaddr,
                len:   paxi_alen,
                size:  paxi_asize,
                burst: paxi_aburst
            };
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awsize  <= '0;
            axi_awburst <= '0;
        end else if (wr_disp) begin
            axi_awvalid <= 1'b1;
            axi_awaddr  <= head.addr;
            axi_awlen   <= head.len;
            axi_awsize  <= head.size;
            axi_awburst <= head.burst;
        end else if (axi_awready) begin
            axi_awvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            axi_arlen   <= '0;
            axi_arsize  <= '0;
            axi_arburst <= '0;
        end else if (rd_disp) begin
            axi_arvalid <= 1'b1;
            axi_araddr  <= head.addr;
            axi_arlen   <= head.len;
            axi_arsize  <= head.size;
            axi_arburst <= head.burst;
        end else if (axi_arready) begin
            axi_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_outstanding <= '0;
        end else begin
            case ({wr_disp, wr_dec})
                2'b10:   wr_outstanding <= wr_outstanding + CW'(1);
                2'b01:   wr_outstanding <= wr_outstanding - CW'(1);
                default: wr_outstanding <= wr_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_outstanding <= '0;
        end else begin
            case ({rd_disp, rd_dec})
                2'b10:   rd_outstanding <= rd_outstanding + CW'(1);
                2'b01:   rd_outstanding <= rd_outstanding - CW'(1);
                default: rd_outstanding <= rd_outstanding;
            endcase
        end
    end

endmodule
